// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder: FSM states, operation codes
// and the strobe-pair control decode used to classify a request.
package memory_responder_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    ACK  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_ERR = 2'b10
  } op_t;

  typedef struct packed {
    logic req;
    op_t  op;
  } ctrl_t;

  // Control matrix: both strobes low is a request, but an illegal one.
  function automatic ctrl_t decode_strobes(input logic rd_n, input logic wr_n);
    ctrl_t c;
    c.req = !(rd_n && wr_n);
    case ({rd_n, wr_n})
      2'b00:   c.op = OP_ERR;
      2'b01:   c.op = OP_RD;
      2'b10:   c.op = OP_WR;
      default: c.op = OP_RD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/memory_responder_memory_array.sv
// Storage for the memory responder: synchronous write, combinational read.
module MemoryArray #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_responder.sv
// Strobe-driven memory responder: latches a request, inserts WAIT_STATES busy
// cycles, then commits the access and pulses ack (and err for illegal requests).
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rd_ni,
  input  logic                  wr_ni,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  ack_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    (WAIT_STATES == 0) ? '0 : WAIT_W'(WAIT_STATES - 1);

  state_t                state;
  op_t                   op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [WAIT_W-1:0]     wait_cnt;

  ctrl_t                 ctrl;
  logic                  enter_ack;
  op_t                   acc_op;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // With zero wait states the access commits on the latching edge itself,
  // so the memory port must see the live request rather than the latches.
  always_comb begin
    ctrl      = decode_strobes(rd_ni, wr_ni);
    acc_op    = op_q;
    acc_addr  = addr_q;
    acc_data  = data_q;
    enter_ack = 1'b0;
    case (state)
      IDLE: begin
        acc_op    = ctrl.op;
        acc_addr  = addr_i;
        acc_data  = data_i;
        enter_ack = ctrl.req && (WAIT_STATES == 0);
      end
      BUSY:    enter_ack = (wait_cnt == '0);
      default: enter_ack = 1'b0;
    endcase
    mem_we = enter_ack && (acc_op == OP_WR) && !reset_i;
  end

  MemoryArray #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk_i(clk_i),
    .we   (mem_we),
    .addr (acc_addr),
    .wdata(acc_data),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      busy_o   <= 1'b0;
      data_o   <= '0;
      wait_cnt <= '0;
    end else begin
      ack_o <= enter_ack;
      err_o <= enter_ack && (acc_op == OP_ERR);
      if (enter_ack && (acc_op == OP_RD)) data_o <= mem_rdata;
      case (state)
        IDLE: begin
          if (ctrl.req) begin
            op_q     <= ctrl.op;
            addr_q   <= addr_i;
            data_q   <= data_i;
            wait_cnt <= WAIT_LOAD;
            busy_o   <= 1'b1;
            state    <= (WAIT_STATES == 0) ? ACK : BUSY;
          end
        end
        BUSY: begin
          if (wait_cnt == '0) state <= ACK;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        ACK: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder with WAIT_STATES=2 and WAIT_STATES=0 instances.
module tb_memory_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr, wdata;
  logic       rd_n2, wr_n2, rd_n0, wr_n0;
  logic [7:0] data2, data0;
  logic       ack2, busy2, err2, ack0, busy0, err0;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] model [256];
  logic [7:0] last2;
  logic [7:0] sb2[$];
  logic [7:0] sb0[$];

  always #5 clk = ~clk;

  memory_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(2)) dut2 (
    .clk_i(clk), .reset_i(reset), .addr_i(addr), .data_i(wdata),
    .rd_ni(rd_n2), .wr_ni(wr_n2), .data_o(data2), .ack_o(ack2),
    .busy_o(busy2), .err_o(err2)
  );

  memory_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .reset_i(reset), .addr_i(addr), .data_i(wdata),
    .rd_ni(rd_n0), .wr_ni(wr_n0), .data_o(data0), .ack_o(ack0),
    .busy_o(busy0), .err_o(err0)
  );

  // Drive one single-cycle strobe to the WAIT_STATES=2 instance; returns just after the sampling edge.
  task automatic issue2(input logic rd_n, input logic wr_n, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wdata = d; rd_n2 = rd_n; wr_n2 = wr_n;
    @(posedge clk);
    #1;
    rd_n2 = 1'b1; wr_n2 = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy2 got=%b exp=0", busy2); end
    checks++; if (ack2 !== 1'b0) begin failures++; $display("FAIL reset_ack2 got=%b exp=0", ack2); end
    checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL reset_err2 got=%b exp=0", err2); end
    checks++; if (data2 !== 8'h00) begin failures++; $display("FAIL reset_data2 got=%h exp=00", data2); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy0 got=%b exp=0", busy0); end
    checks++; if (data0 !== 8'h00) begin failures++; $display("FAIL reset_data0 got=%h exp=00", data0); end
    reset = 1'b0;
    last2 = 8'h00;
  endtask

  task automatic test_write;
    logic [7:0] exp;
    sb2.push_back(last2);
    model[8'h10] = 8'hA5;
    issue2(1'b1, 1'b0, 8'h10, 8'hA5);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL write_busy_c%0d got=%b exp=1", k, busy2); end
      checks++; if (ack2 !== (k == 3)) begin failures++; $display("FAIL write_ack_c%0d got=%b exp=%b", k, ack2, (k == 3)); end
      if (ack2 === 1'b1) begin
        exp = (sb2.size() > 0) ? sb2.pop_front() : 8'hxx;
        checks++; if (data2 !== exp) begin failures++; $display("FAIL write_data_hold got=%h exp=%h", data2, exp); end
      end
    end
    @(negedge clk);
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL write_busy_after got=%b exp=0", busy2); end
  endtask

  task automatic test_read;
    logic [7:0] exp;
    sb2.push_back(model[8'h10]);
    last2 = model[8'h10];
    issue2(1'b0, 1'b1, 8'h10, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (ack2 !== (k == 3)) begin failures++; $display("FAIL read_ack_c%0d got=%b exp=%b", k, ack2, (k == 3)); end
      if (ack2 === 1'b1) begin
        exp = (sb2.size() > 0) ? sb2.pop_front() : 8'hxx;
        checks++; if (data2 !== exp) begin failures++; $display("FAIL read_data got=%h exp=%h", data2, exp); end
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (data2 !== last2) begin failures++; $display("FAIL read_hold_%0d got=%h exp=%h", k, data2, last2); end
      checks++; if (ack2 !== 1'b0) begin failures++; $display("FAIL read_ack_after_%0d got=%b exp=0", k, ack2); end
    end
  endtask

  task automatic test_error;
    logic [7:0] exp;
    issue2(1'b1, 1'b0, 8'h20, 8'h77);
    model[8'h20] = 8'h77;
    repeat (4) @(negedge clk);
    sb2.push_back(last2);
    issue2(1'b0, 1'b0, 8'h20, 8'h3C);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (ack2 !== (k == 3)) begin failures++; $display("FAIL err_ack_c%0d got=%b exp=%b", k, ack2, (k == 3)); end
      checks++; if (err2 !== (k == 3)) begin failures++; $display("FAIL err_err_c%0d got=%b exp=%b", k, err2, (k == 3)); end
      if (ack2 === 1'b1) begin
        exp = (sb2.size() > 0) ? sb2.pop_front() : 8'hxx;
        checks++; if (data2 !== exp) begin failures++; $display("FAIL err_data_unchanged got=%h exp=%h", data2, exp); end
      end
    end
    @(negedge clk);
    sb2.push_back(model[8'h20]);
    last2 = model[8'h20];
    issue2(1'b0, 1'b1, 8'h20, 8'h00);
    repeat (3) @(negedge clk);
    checks++; if (ack2 !== 1'b1) begin failures++; $display("FAIL err_readback_ack got=%b exp=1", ack2); end
    checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL err_readback_err got=%b exp=0", err2); end
    exp = (sb2.size() > 0) ? sb2.pop_front() : 8'hxx;
    checks++; if (data2 !== exp) begin failures++; $display("FAIL err_mem_unchanged got=%h exp=%h", data2, exp); end
  endtask

  task automatic test_reset_busy;
    logic [7:0] exp;
    issue2(1'b1, 1'b0, 8'h30, 8'h11);
    model[8'h30] = 8'h11;
    repeat (4) @(negedge clk);
    issue2(1'b1, 1'b0, 8'h30, 8'h5A);
    @(negedge clk);
    checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL rstbusy_in_busy got=%b exp=1", busy2); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    last2 = 8'h00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (ack2 !== 1'b0) begin failures++; $display("FAIL rstbusy_ack_%0d got=%b exp=0", k, ack2); end
      checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL rstbusy_busy_%0d got=%b exp=0", k, busy2); end
      checks++; if (data2 !== 8'h00) begin failures++; $display("FAIL rstbusy_data_%0d got=%h exp=00", k, data2); end
    end
    sb2.push_back(model[8'h30]);
    last2 = model[8'h30];
    issue2(1'b0, 1'b1, 8'h30, 8'h00);
    repeat (3) @(negedge clk);
    checks++; if (ack2 !== 1'b1) begin failures++; $display("FAIL rstbusy_read_ack got=%b exp=1", ack2); end
    exp = (sb2.size() > 0) ? sb2.pop_front() : 8'hxx;
    checks++; if (data2 !== exp) begin failures++; $display("FAIL rstbusy_mem_kept got=%h exp=%h", data2, exp); end
  endtask

  task automatic test_reset_strobe;
    logic [7:0] exp;
    @(negedge clk);
    reset = 1'b1; addr = 8'h30; rd_n2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL rststb_busy_%0d got=%b exp=0", k, busy2); end
    end
    reset = 1'b0;
    sb2.push_back(model[8'h30]);
    last2 = model[8'h30];
    @(posedge clk);
    #1;
    rd_n2 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL rststb_busy_c%0d got=%b exp=1", k, busy2); end
      checks++; if (ack2 !== (k == 3)) begin failures++; $display("FAIL rststb_ack_c%0d got=%b exp=%b", k, ack2, (k == 3)); end
      if (ack2 === 1'b1) begin
        exp = (sb2.size() > 0) ? sb2.pop_front() : 8'hxx;
        checks++; if (data2 !== exp) begin failures++; $display("FAIL rststb_data got=%h exp=%h", data2, exp); end
      end
    end
  endtask

  task automatic test_back_to_back_wait0;
    logic [7:0] exp;
    @(negedge clk);
    addr = 8'hFF; wdata = 8'hC3; wr_n0 = 1'b0;
    model[8'hFF] = 8'hC3;
    @(posedge clk);
    #1;
    wr_n0 = 1'b1;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin failures++; $display("FAIL w0_write_ack got=%b exp=1", ack0); end
    checks++; if (data0 !== 8'h00) begin failures++; $display("FAIL w0_write_data got=%h exp=00", data0); end
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL w0_idle_busy got=%b exp=0", busy0); end
    for (int i = 0; i < 4; i++) sb0.push_back(model[8'hFF]);
    rd_n0 = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      checks++; if (ack0 !== (i % 2 == 0)) begin failures++; $display("FAIL w0_ack_%0d got=%b exp=%b", i, ack0, (i % 2 == 0)); end
      checks++; if (busy0 !== (i % 2 == 0)) begin failures++; $display("FAIL w0_busy_%0d got=%b exp=%b", i, busy0, (i % 2 == 0)); end
      if (ack0 === 1'b1) begin
        exp = (sb0.size() > 0) ? sb0.pop_front() : 8'hxx;
        checks++; if (data0 !== exp) begin failures++; $display("FAIL w0_data_%0d got=%h exp=%h", i, data0, exp); end
      end
    end
    rd_n0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL w0_stop_ack_%0d got=%b exp=0", i, ack0); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; addr = 8'h00; wdata = 8'h00;
    rd_n2 = 1'b1; wr_n2 = 1'b1; rd_n0 = 1'b1; wr_n0 = 1'b1;
    repeat (2) @(posedge clk);
    test_reset;
    test_write;
    test_read;
    test_error;
    test_reset_busy;
    test_reset_strobe;
    test_back_to_back_wait0;
    checks++; if (sb2.size() != 0) begin failures++; $display("FAIL sb2_drain got=%0d exp=0", sb2.size()); end
    checks++; if (sb0.size() != 0) begin failures++; $display("FAIL sb0_drain got=%0d exp=0", sb0.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, setting the data bus width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, setting the address width and a memory depth of 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter WAIT_STATES, default 2, setting the number of BUSY cycles inserted per access (legal range 0-15).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port addr_i, input, ADDR_WIDTH bits: access address, driven from the MAR output.
REQ-007 The block SHALL have port data_i, input, DATA_WIDTH bits: write data.
REQ-008 The block SHALL have port rd_ni, input, 1 bit: read strobe, active-low.
REQ-009 The block SHALL have port wr_ni, input, 1 bit: write strobe, active-low.
REQ-010 The block SHALL have port data_o, output, DATA_WIDTH bits: registered read data.
REQ-011 The block SHALL have port ack_o, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port busy_o, output, 1 bit: high whenever a transaction is in progress.
REQ-013 The block SHALL have port err_o, output, 1 bit: one-cycle pulse, concurrent with ack_o, on an illegal request.

Function
REQ-014 The block SHALL implement the FSM states IDLE, BUSY and ACK.
REQ-015 In IDLE, with exactly one strobe low, the block SHALL latch addr_i, data_i and the operation at the rising edge, then enter BUSY, or enter ACK when WAIT_STATES=0.
REQ-016 In IDLE, with both strobes low, the block SHALL latch the request as illegal and follow the same timing, with err_o=1 in ACK, no memory write and data_o unchanged.
REQ-017 On entry to BUSY, the block SHALL load the wait counter with WAIT_STATES-1, decrement it each cycle and go to ACK on the cycle after it reads 0, giving exactly WAIT_STATES BUSY cycles.
REQ-018 The block SHALL write the latched data to the latched address on the clock edge that enters ACK.
REQ-019 For a read, the block SHALL load data_o with mem[latched address] on the clock edge that enters ACK, and hold data_o until the next completed read or reset.
REQ-020 The block SHALL hold ack_o=1 for exactly the one ACK cycle, then return to IDLE.
REQ-021 The block SHALL ignore strobes in BUSY and ACK, and ignore changes on addr_i/data_i after latching.
REQ-022 A strobe still low in the IDLE cycle after ACK SHALL start a new transaction, so the back-to-back period is WAIT_STATES+2 cycles; the requester deasserts the strobe in the ACK cycle to avoid a repeat.
REQ-023 The block SHALL drive busy_o=1 in BUSY and ACK, and busy_o=0 in IDLE.
REQ-024 Address decoding SHALL cover the full 2**ADDR_WIDTH range, with no wrap-around or out-of-range case.

Reset
REQ-025 Reset SHALL set state=IDLE, ack_o=0, err_o=0, busy_o=0, data_o=0 and wait counter=0 on the next rising edge.
REQ-026 Reset asserted in BUSY SHALL abort the transaction with no memory write and no ack_o pulse.
REQ-027 Reset asserted in the ACK cycle SHALL take precedence for the next state, but the write already committed on entry to ACK SHALL remain.
REQ-028 Reset SHALL NOT clear memory contents.
REQ-029 A strobe low during reset SHALL be ignored; the request is sampled in the first IDLE cycle after reset_i falls.

Structure
REQ-030 The FSM state encodings (IDLE=2'b00, BUSY=2'b01, ACK=2'b10) and the operation codes (OP_RD, OP_WR, OP_ERR) SHALL reside in the shared definitions include, alongside the control-matrix encodings.
REQ-031 The storage array SHALL be a sub-module named MemoryArray: synchronous write, combinational read, parameterised by DATA_WIDTH and ADDR_WIDTH.
REQ-032 The FSM, wait counter and request latches SHALL reside in memory_responder itself.

Verification
REQ-033 The bench SHALL cover: WAIT_STATES=2, write 8'hA5 to addr 8'h10 (wr_ni low 1 cycle) -> busy_o high 3 cycles, ack_o high on cycle 3 after sampling, mem[8'h10]=8'hA5.
REQ-034 The bench SHALL cover: subsequent read of addr 8'h10 -> ack_o pulse 3 cycles after sampling, data_o=8'hA5 in the ACK cycle and held afterwards.
REQ-035 The bench SHALL cover: WAIT_STATES=0, rd_ni held low continuously on addr 8'hFF -> ack_o every 2nd cycle, data_o=mem[8'hFF].
REQ-036 The bench SHALL cover: rd_ni and wr_ni both low, data_i=8'h3C, addr 8'h20 -> err_o and ack_o pulse together, mem[8'h20] and data_o unchanged.
REQ-037 The bench SHALL cover: write 8'h5A to 8'h30 with reset_i pulsed in the first BUSY cycle -> no ack_o, outputs 0, mem[8'h30] keeps its old value.
REQ-038 The bench SHALL cover: reset_i held 3 cycles while rd_ni is low -> busy_o stays 0 until the first IDLE cycle after release, then a normal read completes.
